// File: rtl/io_timer_pkg.sv
// Shared constants for the two-channel IO timer: register map and bit positions.
package io_timer_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned SYNC_DEFAULT  = 2;

  // Register select, taken from addr[2:1]
  localparam logic [1:0] REG_MODE0 = 2'd0;
  localparam logic [1:0] REG_MODE1 = 2'd1;
  localparam logic [1:0] REG_INIT0 = 2'd2;
  localparam logic [1:0] REG_INIT1 = 2'd3;

  // MODE register bits
  localparam int unsigned MODE_SRC = 0;
  localparam int unsigned MODE_RPT = 1;

  // STAT register bits
  localparam int unsigned STAT_RUN   = 15;
  localparam int unsigned STAT_CDONE = 1;
  localparam int unsigned STAT_TDONE = 0;

endpackage

// File: rtl/io_timer_channel.sv
// One timer/counter channel: mode/init/count state, pulse synchronizer, terminal-count logic.
module io_timer_channel
  import io_timer_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_we,
  input  logic             init_we,
  input  logic             stat_rd,
  input  logic [CNT_W-1:0] wdata,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] stat,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [1:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       init_q, init_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   run_q, run_d;
  logic                   tdone_q, tdone_d;
  logic                   cdone_q, cdone_d;
  logic                   tc_q, tc_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_d_q;
  logic                   pulse_edge;
  logic                   tick;

  // Synchronizer chain and delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      synced_d_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      synced_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_edge = sync_q[SYNC_STAGES-1] & ~synced_d_q;
  // Edges arriving while stopped are simply dropped
  assign tick       = run_q & (mode_q[MODE_SRC] ? pulse_edge : 1'b1);

  // Next-state: bus writes take priority over a coinciding terminal tick
  always_comb begin
    mode_d  = mode_q;
    init_d  = init_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    tdone_d = tdone_q;
    cdone_d = cdone_q;
    tc_d    = 1'b0;
    if (mode_we) begin
      mode_d  = wdata[1:0];
      run_d   = 1'b0;
      tdone_d = 1'b0;
      cdone_d = 1'b0;
    end else if (init_we) begin
      init_d  = wdata;
      cnt_d   = wdata;
      run_d   = (wdata != '0);
      tdone_d = 1'b0;
      cdone_d = 1'b0;
    end else begin
      // Read-clear first so a terminal count on the same edge re-sets the flag
      if (stat_rd) begin
        tdone_d = 1'b0;
        cdone_d = 1'b0;
      end
      if (tick) begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
          tc_d = 1'b1;
          if (mode_q[MODE_SRC]) cdone_d = 1'b1;
          else                  tdone_d = 1'b1;
          if (mode_q[MODE_RPT]) begin
            cnt_d = init_q;
          end else begin
            cnt_d = '0;
            run_d = 1'b0;
          end
        end
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      init_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      tdone_q <= 1'b0;
      cdone_q <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      tdone_q <= tdone_d;
      cdone_q <= cdone_d;
      tc_q    <= tc_d;
    end
  end

  // Status word assembly
  always_comb begin
    stat             = '0;
    stat[STAT_RUN]   = run_q;
    stat[STAT_CDONE] = cdone_q;
    stat[STAT_TDONE] = tdone_q;
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;

endmodule

// File: rtl/io_timer.sv
// Two-channel timer/counter on the IO bus: address decode and read mux around two channels.
module io_timer
  import io_timer_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic [2:0]       addr,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] rdata,
  input  logic [1:0]       pulse_in,
  output logic [1:0]       tc_out
);

  logic             write_en;
  logic             read_en;
  logic [1:0]       sel;
  logic [1:0]       mode_we;
  logic [1:0]       init_we;
  logic [1:0]       stat_rd;
  logic [CNT_W-1:0] ch_stat [2];
  logic [CNT_W-1:0] ch_cnt  [2];
  logic             unused_addr0;

  // Byte offsets are halfword aligned, so addr[0] carries no information
  assign unused_addr0 = addr[0];

  assign sel      = addr[2:1];
  assign write_en = cs & wr;
  // Write wins when both strobes are high
  assign read_en  = cs & rd & ~wr;

  assign mode_we[0] = write_en & (sel == REG_MODE0);
  assign mode_we[1] = write_en & (sel == REG_MODE1);
  assign init_we[0] = write_en & (sel == REG_INIT0);
  assign init_we[1] = write_en & (sel == REG_INIT1);
  assign stat_rd[0] = read_en  & (sel == REG_MODE0);
  assign stat_rd[1] = read_en  & (sel == REG_MODE1);

  for (genvar i = 0; i < 2; i++) begin : g_ch
    io_timer_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode_we  (mode_we[i]),
      .init_we  (init_we[i]),
      .stat_rd  (stat_rd[i]),
      .wdata    (wdata),
      .pulse_in (pulse_in[i]),
      .stat     (ch_stat[i]),
      .cnt      (ch_cnt[i]),
      .tc       (tc_out[i])
    );
  end

  // Combinational read mux, zero when not reading
  always_comb begin
    rdata = '0;
    if (read_en) begin
      unique case (sel)
        REG_MODE0: rdata = ch_stat[0];
        REG_MODE1: rdata = ch_stat[1];
        REG_INIT0: rdata = ch_cnt[0];
        REG_INIT1: rdata = ch_cnt[1];
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios plus randomized bus/pulse traffic
// compared every cycle against a behavioural model of the timer.
module tb_io_timer;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic [1:0]  pulse_in = '0;
  logic [1:0]  tc_out;

  io_timer #(
    .CNT_W       (16),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .pulse_in (pulse_in),
    .tc_out   (tc_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [1:0]  m_mode [2];
  int unsigned m_init [2];
  int unsigned m_cnt  [2];
  bit          m_run  [2];
  bit          m_td   [2];
  bit          m_cd   [2];
  bit          m_tc   [2];
  bit          m_hist [2][SYNC+1];  // [k] = pulse_in sampled k+1 edges ago

  logic [15:0] obs_rd;
  logic [1:0]  obs_tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_mode[ch] = '0;
      m_init[ch] = 0;
      m_cnt[ch]  = 0;
      m_run[ch]  = 0;
      m_td[ch]   = 0;
      m_cd[ch]   = 0;
      m_tc[ch]   = 0;
      for (int k = 0; k <= SYNC; k++) m_hist[ch][k] = 0;
    end
  endfunction

  function automatic logic [15:0] m_read(input logic c, input logic r, input logic w,
                                         input logic [2:0] a);
    int ch;
    if (!(c && r && !w)) return 16'h0000;
    ch = int'(a[1]);
    if (a[2]) return m_cnt[ch][15:0];
    return {m_run[ch], 13'b0, m_cd[ch], m_td[ch]};
  endfunction

  // Advance the model by one clock edge using the bus/pulse values present at that edge
  function automatic void m_step();
    bit wr_en, rd_en, tgt_mode, tgt_init, tgt_stat, rising, tick;
    wr_en = cs && wr;
    rd_en = cs && rd && !wr;
    for (int ch = 0; ch < 2; ch++) begin
      tgt_mode = wr_en && !addr[2] && (int'(addr[1]) == ch);
      tgt_init = wr_en && addr[2] && (int'(addr[1]) == ch);
      tgt_stat = rd_en && !addr[2] && (int'(addr[1]) == ch);
      // A rising edge becomes visible SYNC edges after it is first sampled
      rising   = m_hist[ch][SYNC-1] && !m_hist[ch][SYNC];
      tick     = m_mode[ch][0] ? rising : 1'b1;
      m_tc[ch] = 0;
      if (tgt_mode) begin
        m_mode[ch] = wdata[1:0];
        m_run[ch]  = 0;
        m_td[ch]   = 0;
        m_cd[ch]   = 0;
      end else if (tgt_init) begin
        m_init[ch] = 32'(wdata);
        m_cnt[ch]  = 32'(wdata);
        m_run[ch]  = (wdata != 0);
        m_td[ch]   = 0;
        m_cd[ch]   = 0;
      end else begin
        if (tgt_stat) begin
          m_td[ch] = 0;
          m_cd[ch] = 0;
        end
        if (m_run[ch] && tick) begin
          if (m_cnt[ch] > 1) begin
            m_cnt[ch] = m_cnt[ch] - 1;
          end else begin
            m_tc[ch] = 1;
            if (m_mode[ch][0]) m_cd[ch] = 1;
            else               m_td[ch] = 1;
            if (m_mode[ch][1]) m_cnt[ch] = m_init[ch];
            else begin
              m_cnt[ch] = 0;
              m_run[ch] = 0;
            end
          end
        end
      end
      for (int k = SYNC; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
      m_hist[ch][0] = pulse_in[ch];
    end
  endfunction

  // One bus cycle: drive, sample and compare mid-cycle, then step across the next edge
  task automatic cyc(input logic c, input logic r, input logic w, input logic [2:0] a,
                     input logic [15:0] d);
    cs = c; rd = r; wr = w; addr = a; wdata = d;
    #2;
    obs_rd = rdata;
    obs_tc = tc_out;
    check("rdata", 32'(rdata), 32'(m_read(c, r, w, a)));
    check("tc_out", 32'(tc_out), 32'({m_tc[1], m_tc[0]}));
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cyc(1'b1, 1'b1, 1'b0, a, 16'h0000);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
  endtask

  initial begin
    logic        c, r, w;
    logic [2:0]  a;
    logic [15:0] d;
    int          op;

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    rd_reg(3'd0);
    check("rst_stat0", 32'(obs_rd), 32'h0);
    check("rst_tc", 32'(obs_tc), 32'h0);

    // Asynchronous reset while counting, with a tc pulse in flight
    wr_reg(3'd4, 16'd5);
    wr_reg(3'd6, 16'd1);
    idle();
    check("pre_rst_tc", 32'(tc_out), 32'h2);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 3'd4;
    #1;
    check("pre_rst_cnt0", 32'(rdata), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_rst_tc", 32'(tc_out), 32'h0);
    check("async_rst_cnt0", 32'(rdata), 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cs = 1'b0; rd = 1'b0;
    rd_reg(3'd0);
    check("post_rst_stat0", 32'(obs_rd), 32'h0);

    // Timer one-shot
    wr_reg(3'd0, 16'h0000);
    wr_reg(3'd4, 16'd3);
    for (int i = 0; i < 4; i++) begin
      rd_reg(3'd4);
      check("oneshot_cnt", 32'(obs_rd), 32'(3 - i));
      check("oneshot_tc", 32'(obs_tc[0]), 32'(i == 3));
    end
    idle();
    check("oneshot_tc_end", 32'(obs_tc), 32'h0);
    rd_reg(3'd0);
    check("oneshot_stat", 32'(obs_rd), 32'h0001);
    rd_reg(3'd0);
    check("oneshot_stat_clr", 32'(obs_rd), 32'h0000);

    // Auto-reload on channel 1
    wr_reg(3'd2, 16'h0002);
    wr_reg(3'd6, 16'd4);
    for (int i = 0; i < 13; i++) begin
      rd_reg(3'd6);
      check("reload_cnt", 32'(obs_rd), 32'(4 - (i % 4)));
      check("reload_tc", 32'(obs_tc[1]), 32'(i > 0 && i % 4 == 0));
    end
    rd_reg(3'd2);
    check("reload_stat", 32'(obs_rd), 32'h8001);
    wr_reg(3'd2, 16'h0000);

    // Counter mode on channel 0
    wr_reg(3'd0, 16'h0001);
    wr_reg(3'd4, 16'd2);
    pulse_in[0] = 1'b1;
    repeat (3) idle();
    pulse_in[0] = 1'b0;
    repeat (6) idle();
    rd_reg(3'd4);
    check("ctr_first_edge", 32'(obs_rd), 32'd1);
    pulse_in[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_reg(3'd4);
      check("ctr_cnt", 32'(obs_rd), 32'(i >= SYNC + 1 ? 0 : 1));
      check("ctr_tc", 32'(obs_tc[0]), 32'(i == SYNC + 1));
    end
    pulse_in[0] = 1'b0;
    rd_reg(3'd0);
    check("ctr_stat", 32'(obs_rd), 32'h0002);
    repeat (3) idle();
    pulse_in[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      check("ctr_stopped_tc", 32'(obs_tc), 32'h0);
    end
    rd_reg(3'd4);
    check("ctr_stopped_cnt", 32'(obs_rd), 32'h0);
    pulse_in[0] = 1'b0;

    // STAT read on the terminal edge keeps the done bit
    wr_reg(3'd0, 16'h0000);
    wr_reg(3'd4, 16'd2);
    rd_reg(3'd4);
    check("coll_rd_cnt", 32'(obs_rd), 32'd2);
    rd_reg(3'd0);
    check("coll_rd_stat_pre", 32'(obs_rd), 32'h8000);
    rd_reg(3'd0);
    check("coll_rd_stat_post", 32'(obs_rd), 32'h0001);
    check("coll_rd_tc", 32'(obs_tc[0]), 32'h1);

    // INIT write on the terminal edge wins
    wr_reg(3'd4, 16'd2);
    idle();
    wr_reg(3'd4, 16'd7);
    rd_reg(3'd4);
    check("coll_init_cnt", 32'(obs_rd), 32'd7);
    check("coll_init_tc", 32'(obs_tc), 32'h0);
    rd_reg(3'd0);
    check("coll_init_stat", 32'(obs_rd), 32'h8000);

    // INIT of zero never starts
    wr_reg(3'd4, 16'd0);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("zero_init_tc", 32'(obs_tc), 32'h0);
    end
    rd_reg(3'd0);
    check("zero_init_stat", 32'(obs_rd), 32'h0000);

    // Bus decode
    cyc(1'b0, 1'b0, 1'b1, 3'd4, 16'd5);
    rd_reg(3'd4);
    check("nocs_write", 32'(obs_rd), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 3'd4, 16'h0000);
    check("nocs_read", 32'(obs_rd), 32'h0);
    wr_reg(3'd2, 16'h0001);
    wr_reg(3'd6, 16'h1234);
    rd_reg(3'd6);
    check("rd_cnt1", 32'(obs_rd), 32'h1234);
    rd_reg(3'd7);
    check("rd_cnt1_a0", 32'(obs_rd), 32'h1234);
    cyc(1'b1, 1'b1, 1'b1, 3'd6, 16'h0055);
    check("rdwr_rdata", 32'(obs_rd), 32'h0);
    rd_reg(3'd6);
    check("rdwr_write", 32'(obs_rd), 32'h0055);
    rd_reg(3'd2);
    check("rd_stat1", 32'(obs_rd), 32'h8000);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      c  = ($urandom_range(0, 99) < 92);
      op = int'($urandom_range(0, 99));
      w  = (op < 8) || (op >= 97);
      r  = (op >= 8 && op < 50) || (op >= 97);
      a  = 3'($urandom_range(0, 7));
      if (a[2]) begin
        if ($urandom_range(0, 9) == 0) d = 16'($urandom_range(0, 40));
        else                           d = 16'($urandom_range(0, 6));
      end else begin
        d = 16'($urandom());
      end
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(0, 3) == 0) pulse_in[ch] = ~pulse_in[ch];
      cyc(c, r, w, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
